alu_op_sequencer: RTL and testbench

Registered, handshaked successor to the combinational ALU op decoder. It decodes {funct, ALU_op} into the execute-stage ALU control bundle and holds it in an output register. Shift and rotate ops whose amount exceeds the shifter's per-pass capacity are split into iterative micro-ops, so a narrow MAX_STEP shifter can serve any DATA_WIDTH. It sits between decode and execute, and stalls decode via in_ready.

---
 rtl/alu_op_sequencer_if.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Handshake bundle between decode, the ALU op sequencer and execute.
//   Input side : in_valid/in_ready handshake plus funct, ALU_op, shamt.
//   Output side: out_valid/out_ready handshake plus the ALU control bundle,
//                micro-op step fields and the error flags.
// Modports:
//   master - decode/execute side (drives the op and out_ready)
//   slave  - sequencer side (drives in_ready and the control bundle)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
  parameter int SHAMT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         funct;
  logic [4:0]         ALU_op;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         ALU_control;
  logic               inv_A;
  logic               inv_B;
  logic               B_to_zero;
  logic               c_in;
  logic               shift_A;
  logic               sign;
  logic               less_than;
  logic               equal_to;
  logic               set_CO;
  logic [SHAMT_W-1:0] step_amt;
  logic               step_first;
  logic               step_last;
  logic               err;
  logic               err_seen;

  modport master (
    output in_valid, funct, ALU_op, shamt, out_ready,
    input  in_ready, out_valid, ALU_control, inv_A, inv_B, B_to_zero, c_in,
           shift_A, sign, less_than, equal_to, set_CO, step_amt, step_first,
           step_last, err, err_seen
  );

  modport slave (
    input  in_valid, funct, ALU_op, shamt, out_ready,
    output in_ready, out_valid, ALU_control, inv_A, inv_B, B_to_zero, c_in,
           shift_A, sign, less_than, equal_to, set_CO, step_amt, step_first,
           step_last, err, err_seen
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Decodes {funct, ALU_op} into the execute-stage ALU control bundle and holds
// it in an output register behind a valid/ready handshake. Shift/rotate ops
// larger than MAX_STEP are split into several micro-ops so a narrow shifter
// can serve the full datapath width.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - alu_op_sequencer_if.slave (op input, control bundle output)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int SHAMT_W    = 4,
  parameter int MAX_STEP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_op_sequencer_if.slave   bus
);

  if (SHAMT_W != $clog2(DATA_WIDTH)) begin : g_bad_shamt_w
    $error("SHAMT_W must equal clog2(DATA_WIDTH)");
  end
  if ((MAX_STEP < 1) || (MAX_STEP > DATA_WIDTH)) begin : g_bad_max_step
    $error("MAX_STEP must lie in 1..DATA_WIDTH");
  end

  // One extra bit so MAX_STEP == DATA_WIDTH is representable.
  localparam logic [SHAMT_W:0] LP_MAX = (SHAMT_W+1)'(MAX_STEP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ITER = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       inv_a;
    logic       inv_b;
    logic       b_to_zero;
    logic       c_in;
    logic       shift_a;
    logic       sign;
    logic       less_than;
    logic       equal_to;
    logic       set_co;
    logic       err;
  } ctrl_t;

  // True when the remaining amount finishes within this micro-op.
  function automatic logic fits_one(input logic [SHAMT_W-1:0] rem);
    fits_one = ({1'b0, rem} <= LP_MAX);
  endfunction

  // min(rem, MAX_STEP); the else branch only arises when MAX_STEP < rem.
  function automatic logic [SHAMT_W-1:0] step_of(input logic [SHAMT_W-1:0] rem);
    if (fits_one(rem)) begin
      step_of = rem;
    end else begin
      step_of = LP_MAX[SHAMT_W-1:0];
    end
  endfunction

  state_t             r_state;
  state_t             w_state_next;
  ctrl_t              r_ctrl;
  ctrl_t              w_dec;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] r_remaining;
  logic [SHAMT_W-1:0] w_rem_next;
  logic [SHAMT_W-1:0] r_step_amt;
  logic               r_step_first;
  logic               r_step_last;
  logic               r_err_seen;
  logic               w_out_valid;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load;
  logic               w_advance;
  logic               w_clear;

  assign w_out_valid = (r_state != S_IDLE);
  assign w_in_ready  = !w_out_valid | (bus.out_ready & r_step_last);
  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & bus.out_ready;
  assign w_rem_next  = r_remaining - r_step_amt;

  // Decode {funct, ALU_op} into a control bundle; funct matters only for 00000/00001.
  always_comb begin
    w_dec      = '0;
    w_is_shift = 1'b0;
    case (bus.ALU_op)
      5'b00000: begin
        case (bus.funct)
          2'b00: begin w_dec.ctrl = 4'd0; w_dec.sign = 1'b1; end
          2'b01: begin
            w_dec.ctrl = 4'd0; w_dec.inv_a = 1'b1; w_dec.c_in = 1'b1; w_dec.sign = 1'b1;
          end
          2'b10: begin w_dec.ctrl = 4'd2; end
          2'b11: begin w_dec.ctrl = 4'd3; w_dec.inv_b = 1'b1; end
          default: begin w_dec.err = 1'b1; end
        endcase
      end
      5'b00001: begin w_is_shift = 1'b1; w_dec.ctrl = {2'b01, bus.funct}; end
      5'b00010: begin
        w_dec.inv_a = 1'b1; w_dec.c_in = 1'b1; w_dec.sign = 1'b1; w_dec.equal_to = 1'b1;
      end
      5'b00011: begin
        w_dec.inv_a = 1'b1; w_dec.c_in = 1'b1; w_dec.sign = 1'b1; w_dec.less_than = 1'b1;
      end
      5'b00100: begin
        w_dec.inv_a = 1'b1; w_dec.c_in = 1'b1; w_dec.sign = 1'b1;
        w_dec.less_than = 1'b1; w_dec.equal_to = 1'b1;
      end
      5'b00101: begin w_dec.sign = 1'b1; w_dec.set_co = 1'b1; end
      5'b00110: begin w_dec.ctrl = 4'd8; end
      5'b00111: begin w_dec.sign = 1'b1; end
      5'b01000: begin w_dec.inv_a = 1'b1; w_dec.c_in = 1'b1; w_dec.sign = 1'b1; end
      5'b01001: begin w_dec.ctrl = 4'd2; end
      5'b01010: begin w_dec.ctrl = 4'd3; w_dec.inv_b = 1'b1; end
      5'b01011: begin w_is_shift = 1'b1; w_dec.ctrl = 4'd4; end
      5'b01100: begin w_is_shift = 1'b1; w_dec.ctrl = 4'd5; end
      5'b01101: begin w_is_shift = 1'b1; w_dec.ctrl = 4'd6; end
      5'b01110: begin w_is_shift = 1'b1; w_dec.ctrl = 4'd7; end
      5'b01111: begin w_dec.ctrl = 4'd1; w_dec.shift_a = 1'b1; end
      5'b10000: begin w_dec.b_to_zero = 1'b1; w_dec.sign = 1'b1; end
      default:  begin w_dec.err = 1'b1; end
    endcase
  end

  // Next-state logic: load a new op, step to the next micro-op, or drain to idle.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          w_state_next = S_EMIT;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EMIT, S_ITER: begin
        if (w_out_fire && r_step_last && w_in_fire) begin
          w_state_next = S_EMIT;
          w_load       = 1'b1;
        end else if (w_out_fire && r_step_last) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = S_ITER;
          w_advance    = 1'b1;
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  // State, output bundle and micro-op counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ctrl       <= '0;
      r_remaining  <= '0;
      r_step_amt   <= '0;
      r_step_first <= 1'b0;
      r_step_last  <= 1'b0;
      r_err_seen   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_err_seen <= r_err_seen | (w_load & w_dec.err);
      if (w_load) begin
        r_ctrl       <= w_dec;
        r_step_first <= 1'b1;
        if (w_is_shift) begin
          r_remaining <= bus.shamt;
          r_step_amt  <= step_of(bus.shamt);
          r_step_last <= fits_one(bus.shamt);
        end else begin
          r_remaining <= '0;
          r_step_amt  <= '0;
          r_step_last <= 1'b1;
        end
      end else if (w_advance) begin
        r_remaining  <= w_rem_next;
        r_step_amt   <= step_of(w_rem_next);
        r_step_last  <= fits_one(w_rem_next);
        r_step_first <= 1'b0;
      end else if (w_clear) begin
        r_ctrl       <= '0;
        r_remaining  <= '0;
        r_step_amt   <= '0;
        r_step_first <= 1'b0;
        r_step_last  <= 1'b0;
      end else begin
        r_ctrl <= r_ctrl;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.ALU_control = r_ctrl.ctrl;
  assign bus.inv_A       = r_ctrl.inv_a;
  assign bus.inv_B       = r_ctrl.inv_b;
  assign bus.B_to_zero   = r_ctrl.b_to_zero;
  assign bus.c_in        = r_ctrl.c_in;
  assign bus.shift_A     = r_ctrl.shift_a;
  assign bus.sign        = r_ctrl.sign;
  assign bus.less_than   = r_ctrl.less_than;
  assign bus.equal_to    = r_ctrl.equal_to;
  assign bus.set_CO      = r_ctrl.set_co;
  assign bus.err         = r_ctrl.err;
  assign bus.step_amt    = r_step_amt;
  assign bus.step_first  = r_step_first;
  assign bus.step_last   = r_step_last;
  assign bus.err_seen    = r_err_seen;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer with DATA_WIDTH=16, MAX_STEP=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_op_sequencer_if #(.SHAMT_W(4)) bus ();

  alu_op_sequencer #(.DATA_WIDTH(16), .SHAMT_W(4), .MAX_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] bundle();
    return {bus.ALU_control, bus.inv_A, bus.inv_B, bus.B_to_zero, bus.c_in,
            bus.shift_A, bus.sign, bus.less_than, bus.equal_to, bus.set_CO, bus.err};
  endfunction

  task automatic drive(input logic [1:0] f, input logic [4:0] op, input logic [3:0] sh);
    bus.in_valid = 1'b1;
    bus.funct    = f;
    bus.ALU_op   = op;
    bus.shamt    = sh;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.err_seen !== 1'b0) begin errors++; $display("FAIL reset_err_seen got %0b exp 0", bus.err_seen); end
    checks++; if (bundle() !== 14'h0) begin errors++; $display("FAIL reset_bundle got %h exp 0", bundle()); end
    checks++; if (bus.step_amt !== 4'd0) begin errors++; $display("FAIL reset_step_amt got %0d exp 0", bus.step_amt); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_sub();
    bus.out_ready = 1'b1;
    drive(2'b01, 5'b00000, 4'd0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bundle() !== {4'd0, 10'b1001010000}) begin errors++; $display("FAIL sub_bundle got %h exp %h", bundle(), {4'd0, 10'b1001010000}); end
    checks++; if ({bus.step_first, bus.step_last} !== 2'b11) begin errors++; $display("FAIL sub_first_last got %b exp 11", {bus.step_first, bus.step_last}); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sub_err got %0b exp 0", bus.err); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_ror_split();
    logic [3:0] exp_amt [3];
    exp_amt[0] = 4'd4; exp_amt[1] = 4'd4; exp_amt[2] = 4'd3;
    bus.out_ready = 1'b1;
    drive(2'b10, 5'b00001, 4'd11);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ror_valid[%0d] got %0b exp 1", k, bus.out_valid); end
      checks++; if (bus.ALU_control !== 4'd6) begin errors++; $display("FAIL ror_ctrl[%0d] got %0d exp 6", k, bus.ALU_control); end
      checks++; if (bus.step_amt !== exp_amt[k]) begin errors++; $display("FAIL ror_amt[%0d] got %0d exp %0d", k, bus.step_amt, exp_amt[k]); end
      checks++; if (bus.step_first !== (k == 0)) begin errors++; $display("FAIL ror_first[%0d] got %0b exp %0b", k, bus.step_first, (k == 0)); end
      checks++; if (bus.step_last !== (k == 2)) begin errors++; $display("FAIL ror_last[%0d] got %0b exp %0b", k, bus.step_last, (k == 2)); end
      checks++; if (bus.in_ready !== (k == 2)) begin errors++; $display("FAIL ror_in_ready[%0d] got %0b exp %0b", k, bus.in_ready, (k == 2)); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ror_drain got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_sll_bounds();
    logic [3:0] sh [2];
    sh[0] = 4'd0; sh[1] = 4'd4;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 5'b01100, sh[k]);
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.ALU_control !== 4'd5) begin errors++; $display("FAIL sll_ctrl[%0d] got %0d exp 5", k, bus.ALU_control); end
      checks++; if (bus.step_amt !== sh[k]) begin errors++; $display("FAIL sll_amt[%0d] got %0d exp %0d", k, bus.step_amt, sh[k]); end
      checks++; if ({bus.step_first, bus.step_last} !== 2'b11) begin errors++; $display("FAIL sll_first_last[%0d] got %b exp 11", k, {bus.step_first, bus.step_last}); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sll_single[%0d] got %0b exp 0", k, bus.out_valid); end
    end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(2'b00, 5'b00011, 4'd0);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b exp 1", k, bus.out_valid); end
      checks++; if (bundle() !== {4'd0, 10'b1001011000}) begin errors++; $display("FAIL stall_bundle[%0d] got %h exp %h", k, bundle(), {4'd0, 10'b1001011000}); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %0b exp 0", k, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    drive(2'b00, 5'b00101, 4'd0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %0b exp 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sco_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bundle() !== {4'd0, 10'b0000010010}) begin errors++; $display("FAIL sco_bundle got %h exp %h", bundle(), {4'd0, 10'b0000010010}); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sco_drain got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  tf  [16];
    logic [4:0]  top [16];
    logic [13:0] tex [16];
    tf[0]  = 2'b00; top[0]  = 5'b00000; tex[0]  = {4'd0, 10'b0000010000};
    tf[1]  = 2'b01; top[1]  = 5'b00000; tex[1]  = {4'd0, 10'b1001010000};
    tf[2]  = 2'b10; top[2]  = 5'b00000; tex[2]  = {4'd2, 10'b0000000000};
    tf[3]  = 2'b11; top[3]  = 5'b00000; tex[3]  = {4'd3, 10'b0100000000};
    tf[4]  = 2'b10; top[4]  = 5'b00111; tex[4]  = {4'd0, 10'b0000010000};
    tf[5]  = 2'b11; top[5]  = 5'b01000; tex[5]  = {4'd0, 10'b1001010000};
    tf[6]  = 2'b01; top[6]  = 5'b01001; tex[6]  = {4'd2, 10'b0000000000};
    tf[7]  = 2'b00; top[7]  = 5'b01010; tex[7]  = {4'd3, 10'b0100000000};
    tf[8]  = 2'b11; top[8]  = 5'b00010; tex[8]  = {4'd0, 10'b1001010100};
    tf[9]  = 2'b00; top[9]  = 5'b00100; tex[9]  = {4'd0, 10'b1001011100};
    tf[10] = 2'b01; top[10] = 5'b01111; tex[10] = {4'd1, 10'b0000100000};
    tf[11] = 2'b10; top[11] = 5'b00110; tex[11] = {4'd8, 10'b0000000000};
    tf[12] = 2'b11; top[12] = 5'b10000; tex[12] = {4'd0, 10'b0010010000};
    tf[13] = 2'b10; top[13] = 5'b01011; tex[13] = {4'd4, 10'b0000000000};
    tf[14] = 2'b11; top[14] = 5'b00001; tex[14] = {4'd7, 10'b0000000000};
    tf[15] = 2'b00; top[15] = 5'b01101; tex[15] = {4'd6, 10'b0000000000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tf[i], top[i], 4'd0);
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp 1", i, bus.out_valid); end
      checks++; if (bundle() !== tex[i]) begin errors++; $display("FAIL b2b_bundle[%0d] got %h exp %h", i, bundle(), tex[i]); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", bus.out_valid); end
    checks++; if (bus.err_seen !== 1'b0) begin errors++; $display("FAIL b2b_err_seen got %0b exp 0", bus.err_seen); end
  endtask

  task automatic test_err();
    bus.out_ready = 1'b1;
    drive(2'b01, 5'b10001, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bundle() !== {4'd0, 10'b0000000001}) begin errors++; $display("FAIL err_bundle got %h exp %h", bundle(), {4'd0, 10'b0000000001}); end
    checks++; if ({bus.step_amt, bus.step_first, bus.step_last} !== 6'b0000_11) begin errors++; $display("FAIL err_step got %b exp 000011", {bus.step_amt, bus.step_first, bus.step_last}); end
    checks++; if (bus.err_seen !== 1'b1) begin errors++; $display("FAIL err_seen_set got %0b exp 1", bus.err_seen); end
    tick();
    drive(2'b00, 5'b01001, 4'd0);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b exp 0", bus.err); end
    checks++; if (bus.err_seen !== 1'b1) begin errors++; $display("FAIL err_seen_sticky got %0b exp 1", bus.err_seen); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    drive(2'b00, 5'b01011, 4'd15);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if ({bus.step_amt, bus.step_first, bus.step_last} !== {4'd4, 2'b00}) begin errors++; $display("FAIL rol_second got %b exp 010000", {bus.step_amt, bus.step_first, bus.step_last}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.err_seen !== 1'b0) begin errors++; $display("FAIL rstmid_err_seen got %0b exp 0", bus.err_seen); end
    checks++; if ({bundle(), bus.step_amt} !== 18'h0) begin errors++; $display("FAIL rstmid_bundle got %h exp 0", {bundle(), bus.step_amt}); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d] got %0b exp 0", k, bus.out_valid); end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.funct     = 2'b00;
    bus.ALU_op    = 5'b00000;
    bus.shamt     = 4'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sub();
    test_ror_split();
    test_sll_bounds();
    test_stall();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
